// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings, "operand not read" marker and the
// shadow-stage record shared by hazard_scoreboard and hazard_fwd_sel.
package hazard_pkg;

  // Record field widths; the scoreboard parameters default to these.
  localparam int HZ_RA_W = 5;
  localparam int HZ_T_W  = 2;

  // Forward-select encodings (D uses all four, E uses RF/W/M).
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // Tuse value meaning "this operand is not read".
  localparam logic [HZ_T_W-1:0] TUSE_NONE = '1;

  // Tags carried down the pipe for one instruction; all-zero is a bubble.
  typedef struct packed {
    logic [HZ_RA_W-1:0] rs;
    logic [HZ_RA_W-1:0] rt;
    logic [HZ_RA_W-1:0] dst;
    logic [HZ_T_W-1:0]  tnew;
  } stage_t;

  // Tnew one stage later: count down, stick at zero.
  function automatic logic [HZ_T_W-1:0] tnew_dec(input logic [HZ_T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: nearest-hit priority selector for one source operand.
// Finds the youngest stage (E > M > W) writing the operand, forwards it when
// its result is ready and flags a stall when the consumer needs it too early.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W  = HZ_RA_W,
  parameter int T_W   = HZ_T_W,
  parameter bit USE_E = 1'b1     // 0 for operands that already sit in E
) (
  input  logic [RA_W-1:0] src,
  input  logic [T_W-1:0]  tuse,
  input  logic [RA_W-1:0] dst_e,
  input  logic [T_W-1:0]  tnew_e,
  input  logic [RA_W-1:0] dst_m,
  input  logic [T_W-1:0]  tnew_m,
  input  logic [RA_W-1:0] dst_w,
  input  logic [T_W-1:0]  tnew_w,
  output logic [1:0]      fwd,
  output logic            stall
);

  logic [1:0]     hit_stage;
  logic [T_W-1:0] hit_tnew;

  // Nearest producing stage; register 0 never matches anything.
  always_comb begin
    hit_stage = FWD_RF;
    hit_tnew  = '0;
    if (src != '0) begin
      if (USE_E && (dst_e == src)) begin
        hit_stage = FWD_E;
        hit_tnew  = tnew_e;
      end else if (dst_m == src) begin
        hit_stage = FWD_M;
        hit_tnew  = tnew_m;
      end else if (dst_w == src) begin
        hit_stage = FWD_W;
        hit_tnew  = tnew_w;
      end
    end
  end

  // Forward only a ready result; stall if it will still be late next cycle.
  always_comb begin
    fwd   = (hit_tnew == '0) ? hit_stage : FWD_RF;
    stall = 1'b0;
    if (tuse != TUSE_NONE) begin
      case (hit_stage)
        FWD_E:   stall = (hit_tnew > tuse);
        FWD_M:   stall = (hit_tnew > T_W'(1)) && ((hit_tnew - T_W'(1)) > tuse);
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew hazard unit for the 5-stage F/D/E/M/W pipe.
// D-stage tags are shadowed through E/M/W; stall and forward selects are
// combinational from those shadows plus the D inputs.
// Optional macro HAZARD_MDU_EN adds the mult/div busy window and its stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W        = HZ_RA_W,
  parameter int T_W         = HZ_T_W,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs_d,
  input  logic [RA_W-1:0] rt_d,
  input  logic [T_W-1:0]  tuse_rs_d,
  input  logic [T_W-1:0]  tuse_rt_d,
  input  logic [RA_W-1:0] dst_d,
  input  logic [T_W-1:0]  tnew_d,
  input  logic            md_start_d,
  input  logic            md_div_d,
  input  logic            md_use_d,
  output logic            stall,
  output logic [1:0]      fwd_rs_d,
  output logic [1:0]      fwd_rt_d,
  output logic [1:0]      fwd_rs_e,
  output logic [1:0]      fwd_rt_e,
  output logic            fwd_rt_m,
  output logic            md_busy
);

  stage_t e_reg, m_reg, w_reg;
  stage_t e_next, m_next, w_next;

  logic       hz_stall;
  logic       md_stall;

  logic [RA_W-1:0] op_src  [4];
  logic [T_W-1:0]  op_tuse [4];
  logic [1:0]      op_fwd  [4];
  logic [3:0]      op_stall;

  // Pipe advance: bubble into E on stall, tnew counts down per stage.
  always_comb begin
    e_next = '0;
    if (!stall) begin
      e_next.rs   = rs_d;
      e_next.rt   = rt_d;
      e_next.dst  = dst_d;
      e_next.tnew = tnew_d;
    end
    m_next      = e_reg;
    m_next.tnew = tnew_dec(e_reg.tnew);
    w_next      = m_reg;
    w_next.tnew = tnew_dec(m_reg.tnew);
  end

  // Shadow registers; reset empties the pipe and overrides any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg <= '0;
      m_reg <= '0;
      w_reg <= '0;
    end else begin
      e_reg <= e_next;
      m_reg <= m_next;
      w_reg <= w_next;
    end
  end

  // Operand list: 0/1 are the D sources, 2/3 the E sources (never stall).
  always_comb begin
    op_src[0]  = rs_d;
    op_src[1]  = rt_d;
    op_src[2]  = e_reg.rs;
    op_src[3]  = e_reg.rt;
    op_tuse[0] = tuse_rs_d;
    op_tuse[1] = tuse_rt_d;
    op_tuse[2] = TUSE_NONE;
    op_tuse[3] = TUSE_NONE;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      hazard_fwd_sel #(
        .RA_W  (RA_W),
        .T_W   (T_W),
        .USE_E (gi < 2)
      ) u_sel (
        .src    (op_src[gi]),
        .tuse   (op_tuse[gi]),
        .dst_e  (e_reg.dst),
        .tnew_e (e_reg.tnew),
        .dst_m  (m_reg.dst),
        .tnew_m (m_reg.tnew),
        .dst_w  (w_reg.dst),
        .tnew_w (w_reg.tnew),
        .fwd    (op_fwd[gi]),
        .stall  (op_stall[gi])
      );
    end
  endgenerate

  assign hz_stall = |op_stall;
  assign stall    = hz_stall | md_stall;
  assign fwd_rs_d = op_fwd[0];
  assign fwd_rt_d = op_fwd[1];
  assign fwd_rs_e = op_fwd[2];
  assign fwd_rt_e = op_fwd[3];
  assign fwd_rt_m = (m_reg.rt != '0) && (w_reg.dst == m_reg.rt);

  // Shadow source fields past the last consumer are kept for debug visibility.
  logic shadow_unused;
  assign shadow_unused = ^{m_reg.rs, w_reg.rs, w_reg.rt};

`ifdef HAZARD_MDU_EN
  localparam int MD_MAX   = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_CNT_W = $clog2(MD_MAX + 1);

  logic                md_start_e_reg;
  logic                md_div_e_reg;
  logic [MD_CNT_W-1:0] md_cnt_reg;

  // MDU window: flag follows the op into E, counter loads behind it and drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_e_reg <= 1'b0;
      md_div_e_reg   <= 1'b0;
      md_cnt_reg     <= '0;
    end else begin
      md_start_e_reg <= md_start_d & ~stall;
      md_div_e_reg   <= md_div_d & ~stall;
      if (md_start_e_reg)
        md_cnt_reg <= md_div_e_reg ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
      else if (md_cnt_reg != '0)
        md_cnt_reg <= md_cnt_reg - 1'b1;
    end
  end

  assign md_busy  = (md_cnt_reg != '0) | md_start_e_reg;
  assign md_stall = md_use_d & md_busy;
`else
  localparam int MD_UNUSED_CYCLES = MULT_CYCLES + DIV_CYCLES;
  logic md_inputs_unused;
  assign md_inputs_unused = ^{md_start_d, md_div_d, md_use_d};
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan scenarios followed by random
// traffic, compared every cycle against an in-flight instruction model.
module tb_hazard_scoreboard;

  localparam int RA_W = 5;
  localparam int T_W  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [RA_W-1:0] rs_d, rt_d, dst_d;
  logic [T_W-1:0]  tuse_rs_d, tuse_rt_d, tnew_d;
  logic            md_start_d, md_div_d, md_use_d;
  logic            stall;
  logic [1:0]      fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic            fwd_rt_m, md_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: instruction occupying stage s (0=E,1=M,2=W) with its issue-time tnew.
  int m_rs [3];
  int m_rt [3];
  int m_dst[3];
  int m_tn [3];
  int md_left = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .tuse_rs_d  (tuse_rs_d),
    .tuse_rt_d  (tuse_rt_d),
    .dst_d      (dst_d),
    .tnew_d     (tnew_d),
    .md_start_d (md_start_d),
    .md_div_d   (md_div_d),
    .md_use_d   (md_use_d),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m),
    .md_busy    (md_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles left until the instruction in stage s has its result.
  function automatic int tn_now(input int s);
    return (m_tn[s] > s) ? m_tn[s] - s : 0;
  endfunction

  function automatic int nearest(input int r, input int first);
    if (r == 0) return -1;
    for (int s = first; s < 3; s++)
      if (m_dst[s] == r) return s;
    return -1;
  endfunction

  // Expected select, or -1 when the nearest producer is not ready (don't care).
  function automatic int fwd_code(input int r, input int first);
    int s;
    s = nearest(r, first);
    if (s < 0) return 0;
    if (tn_now(s) != 0) return -1;
    return 3 - s;
  endfunction

  function automatic bit model_busy();
`ifdef HAZARD_MDU_EN
    return md_left > 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_stall();
    int r [2];
    int tu[2];
    int s;
    bit st;
    st    = 1'b0;
    r[0]  = int'(rs_d);
    r[1]  = int'(rt_d);
    tu[0] = int'(tuse_rs_d);
    tu[1] = int'(tuse_rt_d);
    for (int i = 0; i < 2; i++) begin
      if (tu[i] != 3) begin
        s = nearest(r[i], 0);
        if (s == 0 && tn_now(0) > tu[i]) st = 1'b1;
        if (s == 1 && tn_now(1) - 1 > tu[i]) st = 1'b1;
      end
    end
`ifdef HAZARD_MDU_EN
    if (md_use_d && model_busy()) st = 1'b1;
`endif
    return st;
  endfunction

  task automatic set_d(input int rs, input int tu_rs, input int rt, input int tu_rt,
                       input int dst, input int tnew);
    rs_d      = RA_W'(rs);
    tuse_rs_d = T_W'(tu_rs);
    rt_d      = RA_W'(rt);
    tuse_rt_d = T_W'(tu_rt);
    dst_d     = RA_W'(dst);
    tnew_d    = T_W'(tnew);
  endtask

  task automatic nop();
    set_d(0, 3, 0, 3, 0, 0);
  endtask

  task automatic set_md(input bit start, input bit dv, input bit use_md);
    md_start_d = start;
    md_div_d   = dv;
    md_use_d   = use_md;
  endtask

  // Called at a negedge: compare all outputs, then advance the model one edge.
  task automatic model_step(input bit do_chk);
    bit st;
    int e;
    st = model_stall();
    if (do_chk) begin
      check("stall", stall, st);
      e = fwd_code(int'(rs_d), 0);
      if (e >= 0) check("fwd_rs_d", fwd_rs_d, e);
      e = fwd_code(int'(rt_d), 0);
      if (e >= 0) check("fwd_rt_d", fwd_rt_d, e);
      e = fwd_code(m_rs[0], 1);
      if (e >= 0) check("fwd_rs_e", fwd_rs_e, e);
      e = fwd_code(m_rt[0], 1);
      if (e >= 0) check("fwd_rt_e", fwd_rt_e, e);
      check("fwd_rt_m", fwd_rt_m, (m_rt[1] != 0 && m_dst[2] == m_rt[1]));
      check("md_busy", md_busy, model_busy());
    end
    @(posedge clk);
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        m_rs[s] = 0; m_rt[s] = 0; m_dst[s] = 0; m_tn[s] = 0;
      end
      md_left = 0;
    end else begin
      for (int s = 2; s > 0; s--) begin
        m_rs[s] = m_rs[s-1]; m_rt[s] = m_rt[s-1];
        m_dst[s] = m_dst[s-1]; m_tn[s] = m_tn[s-1];
      end
      m_rs[0]  = st ? 0 : int'(rs_d);
      m_rt[0]  = st ? 0 : int'(rt_d);
      m_dst[0] = st ? 0 : int'(dst_d);
      m_tn[0]  = st ? 0 : int'(tnew_d);
      if (md_left > 0) md_left--;
      // Busy for the cycle in E plus the full unit latency afterwards.
      if (!st && md_start_d) md_left = (md_div_d ? 10 : 5) + 1;
    end
    #1;
  endtask

  task automatic step(input bit do_chk);
    @(negedge clk);
    model_step(do_chk);
  endtask

  initial begin
    reset = 1'b1;
    set_md(0, 0, 0);
    nop();
    step(0);
    step(1);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_fwd_rs_e", fwd_rs_e, 0);
    check("rst_fwd_rt_m", fwd_rt_m, 0);
    check("rst_md_busy", md_busy, 0);
    model_step(1);

    // addu $3 then beq $3
    set_d(1, 1, 2, 1, 3, 1); step(1);
    set_d(3, 0, 0, 3, 0, 0);
    @(negedge clk); check("alu_beq_stall", stall, 1); model_step(1);
    @(negedge clk); check("alu_beq_stall_clear", stall, 0);
    check("alu_beq_fwd_rs_d", fwd_rs_d, 2); model_step(1);

    // lw $5 then addu $8,$6,$5
    set_d(1, 1, 0, 3, 5, 2); step(1);
    set_d(6, 1, 5, 1, 8, 1);
    @(negedge clk); check("lw_use_stall", stall, 1); model_step(1);
    @(negedge clk); check("lw_use_stall_clear", stall, 0); model_step(1);
    nop();
    @(negedge clk); check("lw_use_fwd_rt_e", fwd_rt_e, 1); model_step(1);

    // jal then jr $31
    set_d(0, 3, 0, 3, 31, 0); step(1);
    set_d(31, 0, 0, 3, 0, 0);
    @(negedge clk); check("jal_jr_stall", stall, 0);
    check("jal_jr_fwd_rs_d", fwd_rs_d, 3); model_step(1);

    // ori $0 then addu $9,$0,$2
    set_d(1, 1, 0, 3, 0, 1); step(1);
    set_d(0, 1, 2, 1, 9, 1); step(1);
    nop();
    @(negedge clk); check("zero_fwd_rs_e", fwd_rs_e, 0);
    check("zero_stall", stall, 0); model_step(1);

    // lw $7 then sw $7
    set_d(1, 1, 0, 3, 7, 2); step(1);
    set_d(1, 1, 7, 2, 0, 0); step(1);
    nop(); step(1);
    @(negedge clk); check("lw_sw_fwd_rt_m", fwd_rt_m, 1); model_step(1);

    // Reset while lw $7 is in E and a dependent jr waits in D
    set_d(1, 1, 0, 3, 7, 2); step(1);
    reset = 1'b1; set_d(7, 0, 0, 3, 0, 0); step(1);
    reset = 1'b0; set_d(7, 0, 7, 0, 0, 0);
    @(negedge clk);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_fwd_rs_d", fwd_rs_d, 0);
    check("rst_mid_fwd_rt_d", fwd_rt_d, 0);
    check("rst_mid_fwd_rs_e", fwd_rs_e, 0);
    check("rst_mid_fwd_rt_e", fwd_rt_e, 0);
    check("rst_mid_fwd_rt_m", fwd_rt_m, 0);
    model_step(1);
    nop();

`ifdef HAZARD_MDU_EN
    // mult enters E, mflo waits in D through the busy window
    set_md(1, 0, 1); step(1);
    set_md(0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mdu_busy", md_busy, 1);
      check("mdu_stall", stall, 1);
      model_step(1);
    end
    @(negedge clk);
    check("mdu_busy_end", md_busy, 0);
    check("mdu_stall_end", stall, 0);
    model_step(1);
    set_md(0, 0, 0);
`endif

    // Random traffic over a small register set to provoke frequent hits
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_d($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2));
`ifdef HAZARD_MDU_EN
      md_start_d = ($urandom_range(0, 7) == 0);
      md_div_d   = $urandom_range(0, 1) != 0;
      md_use_d   = md_start_d | ($urandom_range(0, 3) == 0);
`else
      set_md($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
`endif
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational stall/forward decoder of the 5-stage MIPS pipeline (F/D/E/M/W).
- Replaces per-instruction-class equations with a Tuse/Tnew scoreboard: the controller supplies pre-decoded read/write tags in D, and the block carries them internally through E/M/W shadow registers.
- From the shadow registers it produces stall and forward selects for D, E and M.
- Optionally tracks a multi-cycle mult/div unit busy window.

Parameters:
- RA_W, 5, register-address width; address 0 is the hardwired zero register.
- T_W, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, busy cycles after a mult issues to E (only with HAZARD_MDU_EN).
- DIV_CYCLES, 10, busy cycles after a div issues to E (only with HAZARD_MDU_EN).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high; clears all scoreboard state.
- rs_d  in  RA_W  D-stage rs address.
- rt_d  in  RA_W  D-stage rt address.
- tuse_rs_d  in  T_W  cycles until rs is consumed (0 = branch/jr in D, 1 = ALU in E, 2 = store data in M); all-ones = not read.
- tuse_rt_d  in  T_W  same encoding, for rt.
- dst_d  in  RA_W  destination register (0 = no write).
- tnew_d  in  T_W  stages until the result exists, counted from E (jal=0, ALU=1, load=2).
- md_start_d  in  1  D holds mult/div (HAZARD_MDU_EN).
- md_div_d  in  1  1 = div, 0 = mult (HAZARD_MDU_EN).
- md_use_d  in  1  D holds mfhi/mflo/mthi/mtlo/mult/div (HAZARD_MDU_EN).
- stall  out  1  freeze F/D, insert bubble into E.
- fwd_rs_d  out  2  forward select: 0 = regfile, 1 = W, 2 = M, 3 = E.
- fwd_rt_d  out  2  forward select, same encoding.
- fwd_rs_e  out  2  forward select: 0 = pipe value, 1 = W, 2 = M.
- fwd_rt_e  out  2  forward select, same encoding.
- fwd_rt_m  out  1  1 = forward W to store data.
- md_busy  out  1  MDU busy (0 when feature absent).

Behaviour:
- Shadow state per stage X in {E, M, W}: rs_X, rt_X, dst_X, tnew_X. Also md_cnt.
- Reset: all shadow state cleared to 0. Outputs then evaluate to 0: stall=0, all fwd=0, md_busy=0.
- Clock edge, no stall: E <= D tags; M <= E; W <= M.
- Clock edge, stall: E <= bubble (all fields 0); M <= E; W <= M.
- Tnew decrement on every advance: tnew_M = sat0(tnew_E - 1), tnew_W = sat0(tnew_M - 1). Saturates at 0, never wraps.
- A stage "hits" operand r when r != 0, dst_X == r and the stage is nearest (priority E > M > W).
- stall = 1 if, for rs or rt of D, with tuse != all-ones and a nearest hit X, tnew_X(as seen next cycle) > tuse. Use tnew_E vs tuse, tnew_M-1 vs tuse, W never stalls.
- fwd_*_d = nearest hit stage whose tnew is 0, else 0. If the nearest hit has tnew > 0, that is the stall case and the value is don't-care.
- fwd_*_e uses rs_E/rt_E against M then W under the same rules.
- fwd_rt_m = (rt_M != 0) & (dst_W == rt_M).
- Forward and stall outputs are purely combinational from registers plus D inputs: zero-cycle latency.
- Writes to register 0 never forward and never stall.
- Reset asserted mid-stream wins over stall. The next cycle behaves as an empty pipe.

Optional Feature:
- Macro: HAZARD_MDU_EN.
- Enabled, counter load: when md_start_d advances into E (no stall), md_cnt <= md_div_d ? DIV_CYCLES : MULT_CYCLES.
- Enabled, counting: md_cnt then decrements each cycle to 0.
- Enabled, busy: md_busy = (md_cnt != 0) | E-stage start flag.
- Enabled, stall: additionally asserted when md_use_d & md_busy.
- Enabled, reset: zeroes md_cnt.
- Disabled: md_* inputs are ignored, md_busy is tied 0, and no counter logic exists.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF/FWD_W/FWD_M/FWD_E encodings.
  - TUSE_NONE (all-ones).
  - Shadow-stage record typedef {rs, rt, dst, tnew}.
- One sub-module, hazard_fwd_sel: the combinational nearest-hit priority selector. It is instantiated for rs_d, rt_d, rs_e and rt_e.

Test Plan:
- ALU then dependent beq:
  - addu $3 (tnew 1) in E, beq rs=$3 (tuse 0) in D -> stall=1 for 1 cycle.
  - Next cycle -> fwd_rs_d=2, stall=0.
- lw then dependent addu:
  - lw $5 in E (tnew 2), addu rt=$5 (tuse 1) -> stall=1 once.
  - Then in E -> fwd_rt_e=1.
- jal then jr $31:
  - jal (tnew 0) in E, jr $31 in D -> stall=0, fwd_rs_d=3.
- Zero register:
  - ori $0 in M, addu rs=$0 in E -> fwd_rs_e=0, stall=0.
- lw then sw, plus reset:
  - lw $7 in W, sw rt=$7 in M -> fwd_rt_m=1.
  - Reset asserted with lw in E -> next cycle stall=0, all fwd=0.
- MDU (HAZARD_MDU_EN, MULT_CYCLES=5):
  - mult enters E -> md_busy=1 for 6 cycles.
  - mflo in D during that window -> stall=1.
  - mflo in D on the 7th cycle -> stall=0.
